// File: rtl/scroll_renderer_if.sv
// ROM read port plus the pixel bus toward vga_adapter.
// master = renderer side, slave = ROM / vga_adapter side.
interface scroll_renderer_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3,
  parameter int AW = 15
);
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] rom_data;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;

  modport master (output rom_addr, vga_x, vga_y, vga_colour, vga_plot,
                  input  rom_data);
  modport slave  (input  rom_addr, vga_x, vga_y, vga_colour, vga_plot,
                  output rom_data);
endinterface

// File: rtl/scroll_renderer.sv
// Vertical scroller: owns the scroll offset and redraws the whole frame on
// every accepted tick. Each sweep reads the background ROM at the scrolled
// source row and streams x/y/colour/plot to vga_adapter.
// Optional feature: define SCROLL_OVERRUN_CNT_EN to add the overrun[7:0]
// port counting ticks dropped while one is already queued.
module scroll_renderer #(
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120,
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int CW      = 3,
  parameter int AW      = 15
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          tick,
  input  logic [YW-1:0] step,
  input  logic          dir,
  input  logic          pause,
  scroll_renderer_if.master bus,
  output logic          busy,
  output logic [YW-1:0] offset
`ifdef SCROLL_OVERRUN_CNT_EN
  ,
  output logic [7:0]    overrun
`endif
);

  typedef enum logic [1:0] {INIT, IDLE, SWEEP, DRAIN} state_t;

  localparam logic [XW-1:0] X_LAST = XW'(XSCREEN - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(YSCREEN - 1);
  localparam logic [YW:0]   YS1    = (YW+1)'(YSCREEN);
  localparam logic [AW-1:0] XS_A   = AW'(XSCREEN);

  state_t        state, state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          pending;
  logic          take;
  logic          last;
  logic [YW:0]   osum;
  logic [YW-1:0] offset_nxt;
  logic [YW:0]   ysum;
  logic [YW-1:0] src_y;
  logic [CW-1:0] colour_q;

  // A tick (new or queued) is served only from IDLE and only when not paused.
  assign take = (state == IDLE) && (tick || pending) && !pause;
  assign last = (x == X_LAST) && (y == Y_LAST);
  assign busy = (state == SWEEP) || (state == DRAIN);

  // Next offset: one extra bit and a single conditional subtract wrap the sum.
  always_comb begin
    osum = dir ? ({1'b0, offset} + YS1 - {1'b0, step})
               : ({1'b0, offset} + {1'b0, step});
    offset_nxt = YW'((osum >= YS1) ? (osum - YS1) : osum);
  end

  // Source row for the current screen row, then linear ROM address.
  always_comb begin
    ysum  = {1'b0, y} + {1'b0, offset};
    src_y = YW'((ysum >= YS1) ? (ysum - YS1) : ysum);
    bus.rom_addr = AW'(src_y) * XS_A + AW'(x);
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= INIT;
    else         state <= state_nxt;
  end

  // Next-state logic; INIT forces one redraw after reset.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    state_nxt = SWEEP;
      IDLE:    if (take) state_nxt = SWEEP;
      SWEEP:   if (last) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // Sweep counters: x inner, y outer; they wrap back to 0 on the last pixel.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (state == SWEEP) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Offset only moves when a tick is taken, so a frame never sees two offsets.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)   offset <= '0;
    else if (take) offset <= offset_nxt;
  end

  // One-deep tick queue: set by ticks outside IDLE, cleared when served.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                        pending <= 1'b0;
    else if (take)                      pending <= 1'b0;
    else if (tick && (state != IDLE))   pending <= 1'b1;
  end

  // Pixel outputs trail the address by one cycle to match ROM read latency.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      bus.vga_plot <= 1'b0;
      bus.vga_x    <= '0;
      bus.vga_y    <= '0;
    end else begin
      bus.vga_plot <= (state == SWEEP);
      if (state == SWEEP) begin
        bus.vga_x <= x;
        bus.vga_y <= y;
      end
    end
  end

  // Hold the last plotted colour so the colour output stays put between plots.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)           colour_q <= '0;
    else if (bus.vga_plot) colour_q <= bus.rom_data;
  end

  assign bus.vga_colour = bus.vga_plot ? bus.rom_data : colour_q;

`ifdef SCROLL_OVERRUN_CNT_EN
  // Count ticks dropped because one is already queued; saturates at 255.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)
      overrun <= '0;
    else if (tick && pending && !take && (overrun != 8'hFF))
      overrun <= overrun + 8'd1;
  end
`endif

endmodule
